ternary_cam_search_engine: RTL and testbench

Parametrised ternary CAM with a per-entry stored don't-care mask, per-entry valid bits, and a 2-stage pipelined search. Search returns the full match vector, the lowest-index hit address, and the match count. One command per cycle: search, write, invalidate one entry, or invalidate all. It extends the single-mask TCAM as the lookup primitive for classifier and routing tables.

---
 rtl/ternary_cam_search_engine_if.sv | 24 ++
 rtl/ternary_cam_search_engine.sv | 99 +++++++++
 tb/tb_ternary_cam_search_engine.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ternary_cam_search_engine_if.sv
// ternary_cam_search_engine_if: command and search-result bundle for the TCAM engine.
interface ternary_cam_search_engine_if #(
    parameter int word_size    = 8,
    parameter int address_size = 4
);
    logic                         cmd_valid;
    logic [1:0]                   cmd_op;
    logic [address_size-1:0]      cmd_address;
    logic [word_size-1:0]         cmd_word;
    logic [word_size-1:0]         cmd_mask;
    logic                         result_valid;
    logic                         result_hit;
    logic [address_size-1:0]      result_address;
    logic [(1<<address_size)-1:0] result_match;
    logic [address_size:0]        result_count;
    modport master (
        output cmd_valid, cmd_op, cmd_address, cmd_word, cmd_mask,
        input  result_valid, result_hit, result_address, result_match, result_count
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_address, cmd_word, cmd_mask,
        output result_valid, result_hit, result_address, result_match, result_count
    );
endinterface

// File: rtl/ternary_cam_search_engine.sv
// ternary_cam_search_engine: per-entry masked TCAM with a 2-stage search pipeline
// (register key, compare into match vector, then priority-encode and popcount).
module ternary_cam_search_engine #(
    parameter int word_size    = 8,
    parameter int address_size = 4
) (
    input logic clock,
    input logic reset,
    ternary_cam_search_engine_if.slave bus
);
    localparam int depth = 1 << address_size;
    typedef enum logic [1:0] {op_search = 2'b00, op_write = 2'b01, op_inval = 2'b10, op_inval_all = 2'b11} op_e;
    op_e op;
    logic [word_size-1:0] word_q [depth];
    logic [word_size-1:0] word_d [depth];
    logic [word_size-1:0] mask_q [depth];
    logic [word_size-1:0] mask_d [depth];
    logic [depth-1:0] valid_q, valid_d;
    logic [word_size-1:0] key_q, key_d, key_mask_q, key_mask_d;
    logic s0_valid_q, s0_valid_d, s1_valid_q, s1_valid_d;
    logic [depth-1:0] match_q, match_d;
    logic res_valid_q, res_valid_d, hit_q, hit_d;
    logic [address_size-1:0] addr_q, addr_d;
    logic [depth-1:0] res_match_q, res_match_d;
    logic [address_size:0] count_q, count_d;
    always_comb begin
        op = op_e'(bus.cmd_op);
        word_d = word_q;
        mask_d = mask_q;
        valid_d = valid_q;
        if (bus.cmd_valid && op == op_write) begin
            word_d[bus.cmd_address] = bus.cmd_word;
            mask_d[bus.cmd_address] = bus.cmd_mask;
            valid_d[bus.cmd_address] = 1'b1;
        end
        if (bus.cmd_valid && op == op_inval) valid_d[bus.cmd_address] = 1'b0;
        if (bus.cmd_valid && op == op_inval_all) valid_d = '0;
        s0_valid_d = bus.cmd_valid && op == op_search;
        key_d = s0_valid_d ? bus.cmd_word : key_q;
        key_mask_d = s0_valid_d ? bus.cmd_mask : key_mask_q;
        // Compare sees table state before this edge, so only earlier writes are visible.
        s1_valid_d = s0_valid_q;
        match_d = match_q;
        if (s0_valid_q)
            for (int i = 0; i < depth; i++)
                match_d[i] = valid_q[i] && &(mask_q[i] | key_mask_q | ~(word_q[i] ^ key_q));
        res_valid_d = s1_valid_q;
        hit_d = hit_q;
        addr_d = addr_q;
        res_match_d = res_match_q;
        count_d = count_q;
        if (s1_valid_q) begin
            hit_d = |match_q;
            res_match_d = match_q;
            addr_d = '0;
            count_d = '0;
            for (int i = depth - 1; i >= 0; i--)
                if (match_q[i]) addr_d = address_size'(i);
            for (int i = 0; i < depth; i++)
                count_d = count_d + (address_size + 1)'(match_q[i]);
        end
    end
    always_ff @(posedge clock) begin
        word_q <= word_d;
        mask_q <= mask_d;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            key_q <= '0;
            key_mask_q <= '0;
            s0_valid_q <= 1'b0;
            s1_valid_q <= 1'b0;
            match_q <= '0;
            res_valid_q <= 1'b0;
            hit_q <= 1'b0;
            addr_q <= '0;
            res_match_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            key_q <= key_d;
            key_mask_q <= key_mask_d;
            s0_valid_q <= s0_valid_d;
            s1_valid_q <= s1_valid_d;
            match_q <= match_d;
            res_valid_q <= res_valid_d;
            hit_q <= hit_d;
            addr_q <= addr_d;
            res_match_q <= res_match_d;
            count_q <= count_d;
        end
    end
    assign bus.result_valid = res_valid_q;
    assign bus.result_hit = hit_q;
    assign bus.result_address = addr_q;
    assign bus.result_match = res_match_q;
    assign bus.result_count = count_q;
endmodule

// File: tb/tb_ternary_cam_search_engine.sv
// tb_ternary_cam_search_engine: directed TCAM commands with a queued scoreboard;
// a negedge monitor pops one expectation per result pulse and checks its timing.
module tb_ternary_cam_search_engine;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    typedef struct {
        logic        hit;
        logic [3:0]  addr;
        logic [15:0] match;
        logic [4:0]  count;
        int          due;
    } exp_t;
    exp_t sb[$];
    ternary_cam_search_engine_if #(.word_size(8), .address_size(4)) bus ();
    ternary_cam_search_engine #(.word_size(8), .address_size(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask
    task automatic drive(input logic [1:0] op, input logic [3:0] a, input logic [7:0] w, input logic [7:0] m);
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_address = a;
        bus.cmd_word = w;
        bus.cmd_mask = m;
    endtask
    task automatic search(input logic [7:0] w, input logic [7:0] m, input logic hit,
                          input logic [3:0] addr, input logic [15:0] match, input logic [4:0] count);
        exp_t e;
        drive(2'b00, 4'd0, w, m);
        e.hit = hit;
        e.addr = addr;
        e.match = match;
        e.count = count;
        e.due = cyc + 3;
        sb.push_back(e);
    endtask
    task automatic idle(input int n);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        repeat (n - 1) @(negedge clock);
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.result_valid), 32'd0);
        chk({tag, "_hit"}, 32'(bus.result_hit), 32'd0);
        chk({tag, "_addr"}, 32'(bus.result_address), 32'd0);
        chk({tag, "_match"}, 32'(bus.result_match), 32'd0);
        chk({tag, "_count"}, 32'(bus.result_count), 32'd0);
    endtask
    always @(negedge clock) begin
        if (reset && bus.result_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", 32'(cyc), 32'(e.due));
                chk("hit", 32'(bus.result_hit), 32'(e.hit));
                chk("addr", 32'(bus.result_address), 32'(e.addr));
                chk("match", 32'(bus.result_match), 32'(e.match));
                chk("count", 32'(bus.result_count), 32'(e.count));
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_address = '0;
        bus.cmd_word = '0;
        bus.cmd_mask = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk_zero("reset");
        search(8'h00, 8'hFF, 1'b0, 4'd0, 16'h0000, 5'd0);
        idle(4);
        drive(2'b01, 4'd3, 8'hA5, 8'h00);
        drive(2'b01, 4'd7, 8'hA0, 8'h0F);
        search(8'hA5, 8'h00, 1'b1, 4'd3, 16'h0088, 5'd2);
        search(8'h5A, 8'h00, 1'b0, 4'd0, 16'h0000, 5'd0);
        drive(2'b01, 4'd0, 8'h12, 8'h00);
        search(8'h12, 8'h00, 1'b1, 4'd0, 16'h0001, 5'd1);
        search(8'h34, 8'h00, 1'b0, 4'd0, 16'h0000, 5'd0);
        drive(2'b01, 4'd1, 8'h34, 8'h00);
        drive(2'b10, 4'd3, 8'h00, 8'h00);
        search(8'hA5, 8'h00, 1'b1, 4'd7, 16'h0080, 5'd1);
        idle(4);
        search(8'hA5, 8'h00, 1'b1, 4'd7, 16'h0080, 5'd1);
        search(8'h00, 8'h00, 1'b0, 4'd0, 16'h0000, 5'd0);
        search(8'hA0, 8'h00, 1'b1, 4'd7, 16'h0080, 5'd1);
        search(8'h00, 8'hFF, 1'b1, 4'd0, 16'h0083, 5'd3);
        idle(4);
        for (int i = 0; i < 16; i++) drive(2'b01, 4'(i), 8'(i), 8'hFF);
        search(8'h3C, 8'h00, 1'b1, 4'd0, 16'hFFFF, 5'd16);
        drive(2'b11, 4'd0, 8'h00, 8'h00);
        search(8'h3C, 8'hFF, 1'b0, 4'd0, 16'h0000, 5'd0);
        idle(5);
        drive(2'b01, 4'd5, 8'h77, 8'h00);
        drive(2'b00, 4'd0, 8'h77, 8'h00);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        chk_zero("abort");
        search(8'h77, 8'h00, 1'b0, 4'd0, 16'h0000, 5'd0);
        idle(6);
        chk("pending", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
